// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 2-byte instructions over a byte-wide request/ack
// bus, decodes them, and sequences register-file, ALU and branch controls
// through F0 -> F1 -> (EX) -> (WB) -> F0.
// Optional feature: define BUS_TIMEOUT_EN to add a fetch-ack watchdog that
// raises a sticky bus_err_out and halts after ACK_TIMEOUT stalled cycles.
module instr_sequencer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clka,
  input  logic       reset_in,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       zero_in,
  output logic [2:0] sr1_out,
  output logic [2:0] sr2_out,
  output logic [2:0] rd_out,
  output logic       we_reg_out,
  output logic [2:0] alu_op_out,
  output logic       imm_sel_out,
  output logic [7:0] imm_out,
  output logic [7:0] pc_out,
  output logic       pc_latch_out,
  output logic       illegal_out,
  output logic       halted_out,
  output logic       bus_err_out
);

  typedef enum logic [2:0] {S_F0, S_F1, S_EX, S_WB, S_HALT} state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b01000;
  localparam logic [4:0] OP_BZ   = 5'b01001;
  localparam logic [4:0] OP_JMP  = 5'b01010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  if (ACK_TIMEOUT < 1) begin : g_param_check
    $error("ACK_TIMEOUT must be at least 1");
  end

  state_t     state_q, state_d;
  logic [7:0] pc_q;
  logic [7:0] ir0_q;
  logic [7:0] ir1_q;
  logic       illegal_q;
  logic       fetching;
  logic       is_alu;
  logic       is_illegal;
  logic       branch_taken;
  logic       timeout_hit;
  logic [4:0] op;

  // byte0 is latched in F0, so the opcode is already known during F1
  assign op         = ir0_q[7:3];
  assign is_alu     = (op >= 5'd1) && (op <= 5'd7);
  assign is_illegal = !(is_alu || op == OP_NOP || op == OP_LDI || op == OP_BZ ||
                        op == OP_JMP || op == OP_HALT);
  assign fetching   = (state_q == S_F0) || (state_q == S_F1);
  assign branch_taken = (state_q == S_EX) &&
                        ((op == OP_JMP) || ((op == OP_BZ) && zero_in));

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q;
  logic          bus_err_q;

  assign timeout_hit = fetching && !mem_ack && (wait_cnt_q == CW'(ACK_TIMEOUT - 1));

  // Watchdog: count stalled fetch cycles, clear on every ack, latch error on expiry
  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      if (!fetching || mem_ack) wait_cnt_q <= '0;
      else                      wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  assign bus_err_out = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  // State register
  always_ff @(posedge clka or posedge reset_in) begin
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    if (reset_in) state_q <= S_F0;
    else          state_q <= state_d;
  end

  // Next-state decode; an ack outside F0/F1 has no effect
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_F0: begin
        if (mem_ack)          state_d = S_F1;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_F1: begin
        if (mem_ack) begin
          if (is_alu || op == OP_BZ || op == OP_JMP) state_d = S_EX;
          else if (op == OP_LDI)                     state_d = S_WB;
          else if (op == OP_HALT)                    state_d = S_HALT;
          else                                       state_d = S_F0;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_EX:    state_d = is_alu ? S_WB : S_F0;
      S_WB:    state_d = S_F0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Datapath registers: instruction bytes, program counter, illegal pulse
  always_ff @(posedge clka or posedge reset_in) begin
    // NOTE: every register here is control state, so all of it is reset; there is no storage array to leave unreset.
    if (reset_in) begin
      pc_q      <= 8'h00;
      ir0_q     <= 8'h00;
      ir1_q     <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (state_q == S_F0 && mem_ack) begin
        ir0_q <= mem_rdata;
        pc_q  <= pc_q + 8'd1;
      end
      if (state_q == S_F1 && mem_ack) begin
        ir1_q     <= mem_rdata;
        pc_q      <= pc_q + 8'd1;
        illegal_q <= is_illegal;
      end
      if (branch_taken) pc_q <= ir1_q;
    end
  end

  // Fetch bus, status, and control outputs decoded from state and IR
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    sr1_out      = 3'd0;
    sr2_out      = 3'd0;
    rd_out       = 3'd0;
    we_reg_out   = 1'b0;
    alu_op_out   = 3'd0;
    imm_sel_out  = 1'b0;
    imm_out      = 8'h00;
    pc_latch_out = 1'b0;
    unique case (state_q)
      S_EX: begin
        if (is_alu) begin
          sr1_out    = ir1_q[7:5];
          sr2_out    = ir1_q[4:2];
          alu_op_out = op[2:0];
        end
        pc_latch_out = branch_taken;
      end
      S_WB: begin
        we_reg_out = 1'b1;
        rd_out     = ir0_q[2:0];
        if (is_alu) begin
          sr1_out    = ir1_q[7:5];
          sr2_out    = ir1_q[4:2];
          alu_op_out = op[2:0];
        end
        if (op == OP_LDI) begin
          imm_sel_out = 1'b1;
          imm_out     = ir1_q;
        end
      end
      default: ;
    endcase
  end

  // Reset drops the request combinationally so a pending fetch is abandoned at once
  assign mem_req     = fetching && !reset_in;
  assign mem_addr    = pc_q;
  assign pc_out      = pc_q;
  assign illegal_out = illegal_q;
  assign halted_out  = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with a write-back scoreboard.
module tb_instr_sequencer;

  logic       clka = 1'b0;
  logic       reset_in = 1'b1;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       zero_in = 1'b0;
  logic [2:0] sr1_out, sr2_out, rd_out, alu_op_out;
  logic       we_reg_out, imm_sel_out, pc_latch_out, illegal_out, halted_out, bus_err_out;
  logic [7:0] imm_out, pc_out;

  typedef struct {
    logic [2:0] rd;
    logic       imm_sel;
    logic [7:0] imm;
    logic       is_alu;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] alu_op;
  } wb_exp_t;

  wb_exp_t wb_q[$];
  wb_exp_t wb_e;
  int checks   = 0;
  int failures = 0;

  instr_sequencer #(.ACK_TIMEOUT(15)) dut (
    .clka(clka), .reset_in(reset_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .zero_in(zero_in),
    .sr1_out(sr1_out), .sr2_out(sr2_out), .rd_out(rd_out), .we_reg_out(we_reg_out),
    .alu_op_out(alu_op_out), .imm_sel_out(imm_sel_out), .imm_out(imm_out),
    .pc_out(pc_out), .pc_latch_out(pc_latch_out), .illegal_out(illegal_out),
    .halted_out(halted_out), .bus_err_out(bus_err_out)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, stall, then ack one byte.
  task automatic serve(input logic [7:0] addr, input logic [7:0] data, input int waits);
    int guard = 0;
    while (mem_req !== 1'b1 && guard < 50) begin
      @(negedge clka);
      guard++;
    end
    check("fetch_req", mem_req, 1);
    check("fetch_addr", mem_addr, addr);
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      @(negedge clka);
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clka);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic do_reset();
    #1 reset_in = 1'b1;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_pc", pc_out, 0);
    check("rst_we", we_reg_out, 0);
    check("rst_halted", halted_out, 0);
    check("rst_illegal", illegal_out, 0);
    check("rst_bus_err", bus_err_out, 0);
    check("rst_pc_latch", pc_latch_out, 0);
    @(negedge clka);
    reset_in = 1'b0;
  endtask

  // Scoreboard: every write-back pulse must match the oldest pending expectation
  always @(negedge clka) begin
    if (we_reg_out === 1'b1) begin
      check("wb_pending", (wb_q.size() != 0), 1);
      if (wb_q.size() != 0) begin
        wb_e = wb_q.pop_front();
        check("wb_rd", rd_out, wb_e.rd);
        check("wb_imm_sel", imm_sel_out, wb_e.imm_sel);
        check("wb_imm", imm_out, wb_e.imm);
        if (wb_e.is_alu) begin
          check("wb_sr1", sr1_out, wb_e.sr1);
          check("wb_sr2", sr2_out, wb_e.sr2);
          check("wb_alu_op", alu_op_out, wb_e.alu_op);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // ALU op 1, rd=3, sr1=1, sr2=2: F0 F1 EX WB
    wb_q.push_back('{rd:3'd3, imm_sel:1'b0, imm:8'h00, is_alu:1'b1, sr1:3'd1, sr2:3'd2, alu_op:3'd1});
    serve(8'h00, 8'h0B, 0);
    serve(8'h01, 8'h28, 0);
    check("alu_ex_sr1", sr1_out, 1);
    check("alu_ex_sr2", sr2_out, 2);
    check("alu_ex_op", alu_op_out, 1);
    check("alu_ex_we", we_reg_out, 0);
    check("alu_ex_req", mem_req, 0);
    check("alu_ex_pc", pc_out, 8'h02);
    @(negedge clka);
    check("alu_wb_we", we_reg_out, 1);
    check("alu_wb_rd", rd_out, 3);
    @(negedge clka);
    check("alu_next_req", mem_req, 1);
    check("alu_next_addr", mem_addr, 8'h02);

    // LDI r5, 0xA5: F0 F1 WB
    wb_q.push_back('{rd:3'd5, imm_sel:1'b1, imm:8'hA5, is_alu:1'b0, sr1:3'd0, sr2:3'd0, alu_op:3'd0});
    serve(8'h02, 8'h45, 0);
    serve(8'h03, 8'hA5, 0);
    check("ldi_wb_we", we_reg_out, 1);
    check("ldi_wb_imm_sel", imm_sel_out, 1);
    check("ldi_wb_imm", imm_out, 8'hA5);
    check("ldi_wb_rd", rd_out, 5);
    @(negedge clka);
    check("ldi_next_addr", mem_addr, 8'h04);
    check("ldi_next_we", we_reg_out, 0);

    // BZ 0x40 taken
    zero_in = 1'b1;
    serve(8'h04, 8'h48, 0);
    serve(8'h05, 8'h40, 0);
    check("bz_t_latch", pc_latch_out, 1);
    check("bz_t_we", we_reg_out, 0);
    @(negedge clka);
    zero_in = 1'b0;
    check("bz_t_latch_end", pc_latch_out, 0);
    check("bz_t_pc", pc_out, 8'h40);
    check("bz_t_addr", mem_addr, 8'h40);

    // BZ 0x40 not taken, from address 0
    do_reset();
    serve(8'h00, 8'h48, 0);
    serve(8'h01, 8'h40, 0);
    check("bz_n_latch", pc_latch_out, 0);
    @(negedge clka);
    check("bz_n_pc", pc_out, 8'h02);
    check("bz_n_req", mem_req, 1);

    // NOP: straight back to F0 after F1
    serve(8'h02, 8'h00, 0);
    serve(8'h03, 8'h00, 0);
    check("nop_req", mem_req, 1);
    check("nop_addr", mem_addr, 8'h04);

    // JMP 0xFF, then stalled fetches across the pc wrap
    serve(8'h04, 8'h50, 0);
    serve(8'h05, 8'hFF, 0);
    check("jmp_latch", pc_latch_out, 1);
    @(negedge clka);
    check("jmp_pc", pc_out, 8'hFF);
    serve(8'hFF, 8'h00, 3);
    serve(8'h00, 8'h00, 3);
    check("wrap_pc", pc_out, 8'h01);
    check("wrap_addr", mem_addr, 8'h01);

    // Illegal opcode 10000
    do_reset();
    serve(8'h00, 8'h80, 0);
    serve(8'h01, 8'h00, 0);
    check("ill_pulse", illegal_out, 1);
    check("ill_addr", mem_addr, 8'h02);
    check("ill_we", we_reg_out, 0);
    @(negedge clka);
    check("ill_pulse_end", illegal_out, 0);
    check("ill_addr_hold", mem_addr, 8'h02);

    // ALU op 7, rd=4, sr1=7, sr2=5, with acks during EX/WB that must be ignored
    wb_q.push_back('{rd:3'd4, imm_sel:1'b0, imm:8'h00, is_alu:1'b1, sr1:3'd7, sr2:3'd5, alu_op:3'd7});
    serve(8'h02, 8'h3C, 0);
    serve(8'h03, 8'hF4, 0);
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    check("alu7_ex_sr1", sr1_out, 7);
    check("alu7_ex_sr2", sr2_out, 5);
    check("alu7_ex_op", alu_op_out, 7);
    @(negedge clka);
    check("alu7_wb_pc", pc_out, 8'h04);
    @(negedge clka);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check("ack_ignored_pc", pc_out, 8'h04);
    check("ack_ignored_addr", mem_addr, 8'h04);
    check("ack_ignored_req", mem_req, 1);

    // Reset in the middle of a fetch sequence
    serve(8'h04, 8'h0B, 0);
    #2 reset_in = 1'b1;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_pc", pc_out, 8'h00);
    @(negedge clka);
    reset_in = 1'b0;
    check("midrst_restart_addr", mem_addr, 8'h00);
    serve(8'h00, 8'h00, 0);
    serve(8'h01, 8'h00, 0);
    check("midrst_nop_addr", mem_addr, 8'h02);

    // HALT: no requests, no state change for 20 cycles even with ack toggling
    serve(8'h02, 8'hF8, 0);
    serve(8'h03, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", halted_out, 1);
      check("halt_req", mem_req, 0);
      mem_ack = i[0];
      @(negedge clka);
    end
    mem_ack = 1'b0;
    check("halt_pc", pc_out, 8'h04);

    // Fetch with ack never arriving
    do_reset();
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      @(negedge clka);
      check("to_bus_err_low", bus_err_out, 0);
      check("to_halted_low", halted_out, 0);
    end
    @(negedge clka);
    check("to_bus_err", bus_err_out, 1);
    check("to_halted", halted_out, 1);
    check("to_req", mem_req, 0);
    do_reset();
    check("to_clr_bus_err", bus_err_out, 0);
    check("to_clr_halted", halted_out, 0);
`else
    for (int i = 0; i < 30; i++) begin
      @(negedge clka);
      check("nto_req", mem_req, 1);
      check("nto_bus_err", bus_err_out, 0);
      check("nto_addr", mem_addr, 8'h00);
    end
`endif

    check("wb_queue_drained", wb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
